// File: rtl/fifo_ptr_ctrl_16.sv
// Pointer/flag controller for a 16-entry single-clock FWFT FIFO.
// It drives one-hot storage write enables and the 16:1 read mux select.
module fifo_ptr_ctrl_16 #(
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic        clr_err,
  output logic [15:0] wr_en,
  output logic [3:0]  rd_sel,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_almost_full,
  output logic        o_almost_empty,
  output logic [4:0]  count,
  output logic        o_overflow,
  output logic        o_underflow
);

  localparam logic [4:0] AF5 = 5'(AF_LEVEL);
  localparam logic [4:0] AE5 = 5'(AE_LEVEL);

  logic [4:0] wr_ptr_q, wr_ptr_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       wr_acc, rd_acc;

  // Bit 4 is the wrap bit, so full and empty can be told apart when the indices match.
  assign count          = wr_ptr_q - rd_ptr_q;
  assign o_empty        = (wr_ptr_q == rd_ptr_q);
  assign o_full         = (wr_ptr_q == {~rd_ptr_q[4], rd_ptr_q[3:0]});
  assign o_almost_full  = (count >= AF5);
  assign o_almost_empty = (count <= AE5);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

  // Acceptance uses the pre-edge flags; a pop does not free a slot for a push in the same cycle.
  assign wr_acc = wr & ~o_full;
  assign rd_acc = rd & ~o_empty;

  assign wr_en  = wr_acc ? (16'd1 << wr_ptr_q[3:0]) : 16'd0;
  assign rd_sel = rd_ptr_q[3:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {4'd0, wr_acc};
    rd_ptr_d = rd_ptr_q + {4'd0, rd_acc};
    // A new error takes priority over a clear in the same cycle.
    ovf_d    = (wr & o_full)  | (ovf_q & ~clr_err);
    unf_d    = (rd & o_empty) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl_16.sv
// Directed bench for fifo_ptr_ctrl_16 using hand-computed expectations.
module tb_fifo_ptr_ctrl_16;

  logic        clk, reset, wr, rd, clr_err;
  logic [15:0] wr_en;
  logic [3:0]  rd_sel;
  logic        o_full, o_empty, o_almost_full, o_almost_empty;
  logic [4:0]  count;
  logic        o_overflow, o_underflow;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_ptr_ctrl_16 #(.AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .wr_en(wr_en), .rd_sel(rd_sel), .o_full(o_full), .o_empty(o_empty),
    .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .count(count), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic push(input int n);
    wr = 1'b1;
    repeat (n) cyc();
    wr = 1'b0;
  endtask

  task automatic pop(input int n);
    rd = 1'b1;
    repeat (n) cyc();
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ae", 32'(o_almost_empty), 32'd1);
    chk("rst_af", 32'(o_almost_full), 32'd0);
    chk("rst_rdsel", 32'(rd_sel), 32'd0);
    chk("rst_wren", 32'(wr_en), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_unf", 32'(o_underflow), 32'd0);

    // 1: fill with 16 writes
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1;
      #1;
      chk("fill_wren", 32'(wr_en), 32'd1 << i);
      chk("fill_full_pre", 32'(o_full), 32'd0);
      cyc();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(o_almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_ae", 32'(o_almost_empty), (i + 1 <= 4) ? 32'd1 : 32'd0);
      chk("fill_ovf", 32'(o_overflow), 32'd0);
    end
    wr = 1'b0;
    chk("full_flag", 32'(o_full), 32'd1);
    chk("full_empty", 32'(o_empty), 32'd0);

    // 2: simultaneous wr/rd while full
    wr = 1'b1; rd = 1'b1;
    #1;
    chk("fullrw_wren", 32'(wr_en), 32'd0);
    chk("fullrw_rdsel_pre", 32'(rd_sel), 32'd0);
    cyc();
    wr = 1'b0; rd = 1'b0;
    chk("fullrw_count", 32'(count), 32'd15);
    chk("fullrw_ovf", 32'(o_overflow), 32'd1);
    chk("fullrw_rdsel", 32'(rd_sel), 32'd1);
    chk("fullrw_full", 32'(o_full), 32'd0);

    // 3: simultaneous wr/rd while empty, then clear errors
    do_reset();
    wr = 1'b1; rd = 1'b1;
    #1;
    chk("emptyrw_wren", 32'(wr_en), 32'h0001);
    cyc();
    wr = 1'b0; rd = 1'b0;
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_unf", 32'(o_underflow), 32'd1);
    chk("emptyrw_rdsel", 32'(rd_sel), 32'd0);
    chk("emptyrw_ovf", 32'(o_overflow), 32'd0);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr_unf", 32'(o_underflow), 32'd0);
    chk("clr_count", 32'(count), 32'd1);

    // Clear and new error in the same cycle: set wins
    do_reset();
    rd = 1'b1; clr_err = 1'b1;
    cyc();
    rd = 1'b0; clr_err = 1'b0;
    chk("clrset_unf", 32'(o_underflow), 32'd1);

    // 4: wrap
    do_reset();
    push(10);
    pop(10);
    chk("wrap_empty", 32'(o_empty), 32'd1);
    chk("wrap_rdsel10", 32'(rd_sel), 32'd10);
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1;
      #1;
      chk("wrap_wren", 32'(wr_en), 32'd1 << ((10 + i) % 16));
      cyc();
    end
    wr = 1'b0;
    chk("wrap_count", 32'(count), 32'd10);
    chk("wrap_full", 32'(o_full), 32'd0);
    for (int i = 0; i < 10; i++) begin
      rd = 1'b1;
      #1;
      chk("wrap_rdsel", 32'(rd_sel), 32'((10 + i) % 16));
      cyc();
    end
    rd = 1'b0;
    chk("wrap_drained", 32'(o_empty), 32'd1);
    chk("wrap_rdsel_end", 32'(rd_sel), 32'd4);

    // 5: steady state at count 8
    do_reset();
    push(8);
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; rd = 1'b1;
      #1;
      chk("ss_wren", 32'(wr_en), 32'd1 << ((8 + i) % 16));
      chk("ss_rdsel", 32'(rd_sel), 32'(i % 16));
      cyc();
      chk("ss_count", 32'(count), 32'd8);
      chk("ss_af", 32'(o_almost_full), 32'd0);
      chk("ss_ae", 32'(o_almost_empty), 32'd0);
    end
    wr = 1'b0; rd = 1'b0;

    // 6: async reset mid-operation
    do_reset();
    push(17);
    pop(9);
    chk("pre_rst_count", 32'(count), 32'd7);
    chk("pre_rst_ovf", 32'(o_overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(o_empty), 32'd1);
    chk("async_ovf", 32'(o_overflow), 32'd0);
    chk("async_wren", 32'(wr_en), 32'd0);
    chk("async_rdsel", 32'(rd_sel), 32'd0);
    reset = 1'b0;
    #1;
    wr = 1'b1;
    #1;
    chk("post_rst_wren", 32'(wr_en), 32'h0001);
    cyc();
    wr = 1'b0;
    chk("post_rst_count", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl_16.md
Name: fifo_ptr_ctrl_16

Overview:
- Pointer and flag controller for a 16-entry single-clock FIFO.
- The storage is 16 registers of simd*bw bits, read through a 16:1 FIFO mux tree.
- The block accepts write/read requests, drives one-hot register write enables and the 4-bit mux select, and reports full/empty, almost-full/almost-empty, occupancy and sticky overflow/underflow errors.
- Used by the L0/OFIFO wrappers in front of the MAC array.

Parameters:
- AF_LEVEL, 12: occupancy at or above which o_almost_full asserts (legal range 1..16).
- AE_LEVEL, 4: occupancy at or below which o_almost_empty asserts (legal range 0..15).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr  input  1  write request; data is written this cycle if accepted.
- rd  input  1  read request; pops the head entry if accepted.
- clr_err  input  1  synchronous clear of the sticky error flags.
- wr_en  output  16  one-hot write enable to storage register [wr_ptr[3:0]]; zero when the write is not accepted.
- rd_sel  output  4  select for the 16:1 mux; equals rd_ptr[3:0] (head entry).
- o_full  output  1  count == 16.
- o_empty  output  1  count == 0.
- o_almost_full  output  1  count >= AF_LEVEL.
- o_almost_empty  output  1  count <= AE_LEVEL.
- count  output  5  occupancy, 0..16.
- o_overflow  output  1  sticky: a write was rejected.
- o_underflow  output  1  sticky: a read was rejected.

Behaviour:
- State:
  - wr_ptr and rd_ptr are 5-bit; bit 4 is the wrap bit.
  - count = wr_ptr - rd_ptr, computed mod 32.
  - o_full when pointers differ only in bit 4; o_empty when the pointers are equal.
- Reset (asynchronous, any time, including mid-burst):
  - wr_ptr = 0, rd_ptr = 0, o_overflow = 0, o_underflow = 0.
  - Resulting outputs: count = 0, o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0, rd_sel = 0, wr_en = 0.
  - Storage contents are not cleared.
- Acceptance rules (combinational on the current state):
  - wr_acc = wr & ~o_full.
  - rd_acc = rd & ~o_empty.
  - Flags are evaluated on the pre-edge count. A write into a full FIFO is therefore rejected even if rd is accepted in the same cycle. A read from an empty FIFO is rejected even if wr is accepted in the same cycle. No bypass path.
- wr_en:
  - Combinational: wr_en = wr_acc ? (16'b1 << wr_ptr[3:0]) : 0.
  - The storage register captures data on the same edge that wr_ptr increments.
- rd_sel:
  - Combinational from the registered rd_ptr[3:0].
  - Mux output is first-word-fall-through: head data is valid whenever o_empty = 0, with zero read latency.
  - After an accepted read, the next entry appears the cycle after the edge.
- Pointer update on the clock edge:
  - wr_ptr += wr_acc; rd_ptr += rd_acc, both wrapping mod 32.
  - Simultaneous accepted read and write leaves count unchanged; both pointers advance.
  - Wrap from index 15 to 0 toggles bit 4.
- Flag timing:
  - All flags and count derive from registered pointers.
  - They update one edge after the accepted operation; there is no combinational path from wr/rd to any flag.
- Error flags:
  - o_overflow sets on the edge when wr & o_full.
  - o_underflow sets on the edge when rd & o_empty.
  - Both clear on an edge with clr_err = 1.
  - If clr_err and a new error occur in the same cycle, the set wins (flag stays 1).
  - Rejected requests never move the pointers.
- Width rules: count is 5 bits; AF_LEVEL and AE_LEVEL are compared as 5-bit unsigned values.
- Implementation target: roughly 150 lines of RTL. No latches; all outputs are registered or derived from registers plus the current wr/rd.

Test Plan:
1. Reset, then 16 consecutive wr=1:
   - wr_en walks 0x0001 through 0x8000.
   - count reaches 16; o_full = 1 after the 16th edge.
   - o_almost_full rises after the 12th edge.
   - o_overflow stays 0.
2. From full, drive wr=1, rd=1 for one cycle:
   - Write is rejected (wr_en = 0); read is accepted.
   - count = 15 and o_overflow = 1 on the next cycle.
   - rd_sel goes from 0 to 1.
3. From empty, drive wr=1, rd=1:
   - Write is accepted (wr_en = 0x0001); read is rejected.
   - count = 1, o_underflow = 1, rd_sel stays 0.
   - Then clr_err=1 with rd=0 clears o_underflow on the next edge.
4. Wrap test:
   - Write 10, read 10, then write 10 more.
   - wr_en wraps 0x8000 to 0x0001 after index 15.
   - wr_ptr bit 4 toggles; count = 10.
   - Reading 10 returns rd_sel sequence 10..15, 0..3.
5. Steady state at count=8 with wr=rd=1 for 20 cycles:
   - count stays 8 throughout.
   - o_almost_full = 0 and o_almost_empty = 0 throughout.
   - rd_sel and the wr_en index both advance by 1 every cycle.
6. Reset mid-operation:
   - Assert reset asynchronously (between clock edges) at count=7 with o_overflow = 1.
   - Immediately: count = 0, o_empty = 1, o_overflow = 0, wr_en = 0.
   - First write after release uses wr_en = 0x0001.
